// File: rtl/adma_sequencer.sv
// ADMA2 descriptor engine: fetches 4-word descriptors, decodes them and sequences
// the transfer datapath, sharing the RAM port while fetch_active is high.
module adma_sequencer #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              adma_start,
  input  logic              adma_stop,
  input  logic              dir_in,
  input  logic [ADDR_W-1:0] desc_base,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] data_from_ram,
  output logic              fetch_active,
  output logic              start_transfer,
  output logic              direction,
  output logic [ADDR_W-1:0] address,
  output logic [15:0]       length,
  input  logic              TFC,
  output logic              busy,
  output logic              done,
  output logic              int_req,
  output logic              error,
  output logic [1:0]        err_state,
  output logic [ADDR_W-1:0] desc_ptr
);

  localparam logic [1:0] ST_STOP = 2'b00;
  localparam logic [1:0] ST_FDS  = 2'b01;
  localparam logic [1:0] ST_CADR = 2'b10;
  localparam logic [1:0] ST_TFR  = 2'b11;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              d_valid_q, d_valid_d, d_end_q, d_end_d, d_int_q, d_int_d;
  logic [1:0]        d_act_q, d_act_d;
  logic [15:0]       d_len_q, d_len_d;
  logic [DATA_W-1:0] d_lo_q, d_lo_d, d_hi_q, d_hi_d;
  logic [ADDR_W-1:0] desc_ptr_q, desc_ptr_d, address_q, address_d;
  logic [15:0]       length_q, length_d;
  logic              dir_q, dir_d, stop_pend_q, stop_pend_d;
  logic              start_q, start_d, done_q, done_d, int_req_q, int_req_d;
  logic              error_q, error_d;
  logic [1:0]        err_state_q, err_state_d;
  logic [ADDR_W-1:0] d_addr;
  logic              launch;

  assign d_addr = ADDR_W'({d_hi_q, d_lo_q});
  assign launch = d_valid_q && (d_act_q == ACT_TRAN) && (d_len_q != 16'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_valid_d   = d_valid_q;
    d_end_d     = d_end_q;
    d_int_d     = d_int_q;
    d_act_d     = d_act_q;
    d_len_d     = d_len_q;
    d_lo_d      = d_lo_q;
    d_hi_d      = d_hi_q;
    desc_ptr_d  = desc_ptr_q;
    address_d   = address_q;
    length_d    = length_q;
    dir_d       = dir_q;
    stop_pend_d = stop_pend_q;
    error_d     = error_q;
    err_state_d = err_state_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    int_req_d   = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (adma_start) begin
          desc_ptr_d  = desc_base;
          dir_d       = dir_in;
          error_d     = 1'b0;
          err_state_d = 2'b00;
          stop_pend_d = 1'b0;
          cnt_d       = 3'd0;
          state_d     = ST_FDS;
        end
      end
      ST_FDS: begin
        if (adma_stop) begin
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 3'd1;
          // Word k-1 is on the bus while cnt_q == k; W3 is reserved and dropped.
          case (cnt_q)
            3'd1: begin
              d_valid_d = data_from_ram[0];
              d_end_d   = data_from_ram[1];
              d_int_d   = data_from_ram[2];
              d_act_d   = data_from_ram[5:4];
              d_len_d   = data_from_ram[31:16];
            end
            3'd2: d_lo_d = data_from_ram;
            3'd3: d_hi_d = data_from_ram;
            3'd4: begin
              cnt_d   = 3'd0;
              state_d = ST_CADR;
              if (launch) begin
                start_d   = 1'b1;
                address_d = d_addr;
                length_d  = d_len_q;
              end
            end
            default: ;
          endcase
        end
      end
      ST_CADR: begin
        if (adma_stop) begin
          state_d = ST_STOP;
        end else if (!d_valid_q) begin
          error_d     = 1'b1;
          err_state_d = ST_FDS;
          state_d     = ST_STOP;
        end else if (launch) begin
          state_d = ST_TFR;
        end else begin
          desc_ptr_d = (d_act_q == ACT_LINK) ? d_addr : desc_ptr_q + ADDR_W'(4);
          if (d_end_q) begin
            done_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            state_d = ST_FDS;
          end
        end
      end
      ST_TFR: begin
        if (adma_stop) stop_pend_d = 1'b1;
        if (TFC) begin
          int_req_d = d_int_q;
          if (stop_pend_q || adma_stop) begin
            state_d = ST_STOP;
          end else if (d_end_q) begin
            done_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            desc_ptr_d = desc_ptr_q + ADDR_W'(4);
            state_d    = ST_FDS;
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_q     <= ST_STOP;
      cnt_q       <= 3'd0;
      d_valid_q   <= 1'b0;
      d_end_q     <= 1'b0;
      d_int_q     <= 1'b0;
      d_act_q     <= 2'b00;
      d_len_q     <= 16'd0;
      d_lo_q      <= '0;
      d_hi_q      <= '0;
      desc_ptr_q  <= '0;
      address_q   <= '0;
      length_q    <= 16'd0;
      dir_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      int_req_q   <= 1'b0;
      error_q     <= 1'b0;
      err_state_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_valid_q   <= d_valid_d;
      d_end_q     <= d_end_d;
      d_int_q     <= d_int_d;
      d_act_q     <= d_act_d;
      d_len_q     <= d_len_d;
      d_lo_q      <= d_lo_d;
      d_hi_q      <= d_hi_d;
      desc_ptr_q  <= desc_ptr_d;
      address_q   <= address_d;
      length_q    <= length_d;
      dir_q       <= dir_d;
      stop_pend_q <= stop_pend_d;
      start_q     <= start_d;
      done_q      <= done_d;
      int_req_q   <= int_req_d;
      error_q     <= error_d;
      err_state_q <= err_state_d;
    end
  end

  assign fetch_active   = (state_q == ST_FDS);
  assign ram_read       = fetch_active && !cnt_q[2];
  assign ram_address    = fetch_active ? desc_ptr_q + ADDR_W'(cnt_q) : '0;
  assign busy           = (state_q != ST_STOP);
  assign start_transfer = start_q;
  assign direction      = dir_q;
  assign address        = address_q;
  assign length         = length_q;
  assign done           = done_q;
  assign int_req        = int_req_q;
  assign error          = error_q;
  assign err_state      = err_state_q;
  assign desc_ptr       = desc_ptr_q;

endmodule

// File: tb/tb_adma_sequencer.sv
// Bench for adma_sequencer: descriptor table, directed corner sequences and
// randomized descriptor chains checked against a chain-walking reference model.
module tb_adma_sequencer;

  logic        clk = 1'b0;
  logic        RESET_L, adma_start, adma_stop, dir_in, TFC;
  logic [63:0] desc_base;
  logic        ram_read, fetch_active, start_transfer, direction;
  logic        busy, done, int_req, error;
  logic [63:0] ram_address, address, desc_ptr;
  logic [31:0] data_from_ram;
  logic [15:0] length;
  logic [1:0]  err_state;

  always #5 clk = ~clk;

  adma_sequencer #(.ADDR_W(64), .DATA_W(32)) dut (
    .CLK(clk), .RESET_L(RESET_L), .adma_start(adma_start), .adma_stop(adma_stop),
    .dir_in(dir_in), .desc_base(desc_base), .ram_read(ram_read), .ram_address(ram_address),
    .data_from_ram(data_from_ram), .fetch_active(fetch_active),
    .start_transfer(start_transfer), .direction(direction), .address(address),
    .length(length), .TFC(TFC), .busy(busy), .done(done), .int_req(int_req),
    .error(error), .err_state(err_state), .desc_ptr(desc_ptr)
  );

  // RAM model: one-cycle read latency, 4K words indexed by the low address bits.
  logic [31:0] mem [0:4095];
  always @(posedge clk) data_from_ram <= ram_read ? mem[ram_address[11:0]] : 32'h0;

  logic [63:0] fetch_log[$];
  logic [63:0] launch_addr[$];
  logic [15:0] launch_len[$];
  logic        launch_dir[$];
  int          n_done = 0, n_int = 0, n_bad_read = 0;

  always @(negedge clk) begin
    if (ram_read) fetch_log.push_back(ram_address);
    if (ram_read && !fetch_active) n_bad_read++;
    if (start_transfer) begin
      launch_addr.push_back(address);
      launch_len.push_back(length);
      launch_dir.push_back(direction);
    end
    if (done) n_done++;
    if (int_req) n_int++;
  end

  int n_checks = 0, n_fail = 0;
  int f0, l0, d0, i0, tfc_delay = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_w0(input logic [15:0] len, input logic [1:0] act,
                                        input logic i, input logic e, input logic v);
    return {len, 10'b0, act, 1'b0, i, e, v};
  endfunction

  task automatic put_desc(input logic [63:0] a, input logic [31:0] w0, input logic [63:0] da);
    logic [63:0] ak;
    for (int k = 0; k < 4; k++) begin
      ak = a + 64'(k);
      mem[ak[11:0]] = (k == 0) ? w0 : (k == 1) ? da[31:0] : (k == 2) ? da[63:32] : 32'hDEAD;
    end
  endtask

  task automatic snap();
    f0 = fetch_log.size(); l0 = launch_addr.size(); d0 = n_done; i0 = n_int;
  endtask

  task automatic start_engine(input logic [63:0] base, input logic dir);
    @(negedge clk);
    desc_base = base; dir_in = dir; adma_start = 1'b1;
    @(negedge clk);
    adma_start = 1'b0;
  endtask

  // Runs until idle, answering each launch with TFC after tfc_delay cycles.
  task automatic wait_idle(input int maxc);
    int cd = -1;
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (i > 0) @(negedge clk);
      TFC = 1'b0;
      if (!busy) begin ok = 1'b1; break; end
      if (start_transfer) cd = tfc_delay;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) TFC = 1'b1;
      end
    end
    TFC = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles expected busy=0", maxc);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, busy, 0);           chk({tag, "_ram_read"}, ram_read, 0);
    chk({tag, "_ram_address"}, ram_address, 0); chk({tag, "_fetch"}, fetch_active, 0);
    chk({tag, "_start"}, start_transfer, 0); chk({tag, "_dir"}, direction, 0);
    chk({tag, "_address"}, address, 0);     chk({tag, "_length"}, length, 0);
    chk({tag, "_done"}, done, 0);           chk({tag, "_int"}, int_req, 0);
    chk({tag, "_error"}, error, 0);         chk({tag, "_err_state"}, err_state, 0);
    chk({tag, "_desc_ptr"}, desc_ptr, 0);
  endtask

  // Reference model: walk the descriptor chain in RAM using the decode rules.
  logic [63:0] exp_fetch[$], exp_addr[$];
  logic [15:0] exp_len[$];
  int          exp_done, exp_int;
  logic        exp_err;
  logic [63:0] exp_ptr;

  task automatic model_walk(input logic [63:0] base);
    logic [63:0] ptr, ak, da;
    logic [31:0] w0;
    exp_fetch.delete(); exp_addr.delete(); exp_len.delete();
    exp_done = 0; exp_int = 0; exp_err = 1'b0; ptr = base;
    for (int n = 0; n < 64; n++) begin
      for (int k = 0; k < 4; k++) exp_fetch.push_back(ptr + 64'(k));
      w0 = mem[ptr[11:0]];
      ak = ptr + 64'd1; da[31:0] = mem[ak[11:0]];
      ak = ptr + 64'd2; da[63:32] = mem[ak[11:0]];
      if (!w0[0]) begin exp_err = 1'b1; break; end
      if (w0[5:4] == 2'b10 && w0[31:16] != 16'd0) begin
        exp_addr.push_back(da); exp_len.push_back(w0[31:16]);
        if (w0[2]) exp_int++;
        if (w0[1]) begin exp_done = 1; break; end
        ptr = ptr + 64'd4;
      end else begin
        ptr = (w0[5:4] == 2'b11) ? da : ptr + 64'd4;
        if (w0[1]) begin exp_done = 1; break; end
      end
    end
    exp_ptr = ptr;
  endtask

  task automatic gen_chain(output logic [63:0] base);
    int k;
    logic [63:0] p, nxt, da;
    logic [1:0]  act;
    logic [15:0] len;
    logic        last;
    k = int'($urandom_range(1, 6));
    p = 64'h400 + 64'($urandom_range(0, 63)) * 64'd4;
    base = p;
    for (int i = 0; i < k; i++) begin
      act  = 2'($urandom_range(0, 3));
      len  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      nxt  = p + 64'(4 * $urandom_range(1, 8));
      da   = {$urandom, $urandom};
      last = (i == k - 1);
      if (act == 2'b11) da = nxt; else nxt = p + 64'd4;
      put_desc(p, mk_w0(len, act, 1'($urandom), last, !(last && $urandom_range(0, 7) == 0)), da);
      p = nxt;
    end
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [63:0] da;
    int          launches;
    int          dones;
    int          ints;
    logic        err;
    logic [63:0] ptr;
  } vec_t;

  vec_t vecs[7];
  logic [63:0] rbase;
  int st_cyc, nl;

  initial begin
    vecs[0] = '{mk_w0(16'h0010, 2'b10, 0, 1, 1), 64'h100, 1, 1, 0, 0, 64'h40};
    vecs[1] = '{mk_w0(16'h0010, 2'b10, 0, 1, 0), 64'h100, 0, 0, 0, 1, 64'h40};
    vecs[2] = '{mk_w0(16'h0022, 2'b00, 0, 1, 1), 64'h100, 0, 1, 0, 0, 64'h44};
    vecs[3] = '{mk_w0(16'h0022, 2'b01, 1, 1, 1), 64'h100, 0, 1, 0, 0, 64'h44};
    vecs[4] = '{mk_w0(16'h0000, 2'b10, 1, 1, 1), 64'h100, 0, 1, 0, 0, 64'h44};
    vecs[5] = '{mk_w0(16'h0010, 2'b11, 0, 1, 1), 64'h300, 0, 1, 0, 0, 64'h300};
    vecs[6] = '{mk_w0(16'hABCD, 2'b10, 1, 1, 1), 64'h1_2345_6789, 1, 1, 1, 0, 64'h40};

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    RESET_L = 1'b0; adma_start = 1'b0; adma_stop = 1'b0; dir_in = 1'b0;
    TFC = 1'b0; desc_base = 64'h0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    RESET_L = 1'b1;

    // Launch timing: reads from cycle 1, start_transfer on cycle 6.
    put_desc(64'h40, mk_w0(16'h0010, 2'b10, 0, 1, 1), 64'h100);
    snap();
    start_engine(64'h40, 1'b0);
    chk("t_busy_c1", busy, 1); chk("t_read_c1", ram_read, 1); chk("t_addr_c1", ram_address, 64'h40);
    st_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (start_transfer && st_cyc < 0) st_cyc = c;
    end
    chk("t_launch_cycle", st_cyc, 6);
    TFC = 1'b1; @(negedge clk); TFC = 1'b0;
    wait_idle(50);
    chk("t_nreads", fetch_log.size() - f0, 4);
    for (int k = 0; k < 4; k++) chk("t_read_addr", fetch_log[f0 + k], 64'h40 + 64'(k));

    foreach (vecs[v]) begin
      put_desc(64'h40, vecs[v].w0, vecs[v].da);
      snap();
      start_engine(64'h40, 1'(v));
      wait_idle(100);
      nl = launch_addr.size() - l0;
      chk($sformatf("v%0d_launches", v), nl, vecs[v].launches);
      chk($sformatf("v%0d_done", v), n_done - d0, vecs[v].dones);
      chk($sformatf("v%0d_int", v), n_int - i0, vecs[v].ints);
      chk($sformatf("v%0d_error", v), error, vecs[v].err);
      chk($sformatf("v%0d_err_state", v), err_state, vecs[v].err ? 2'b01 : 2'b00);
      chk($sformatf("v%0d_desc_ptr", v), desc_ptr, vecs[v].ptr);
      if (nl == 1 && vecs[v].launches == 1) begin
        chk($sformatf("v%0d_addr", v), launch_addr[l0], vecs[v].da);
        chk($sformatf("v%0d_len", v), launch_len[l0], vecs[v].w0[31:16]);
        chk($sformatf("v%0d_dir", v), launch_dir[l0], 1'(v));
      end
    end

    // Valid=0: idle exactly 7 cycles after adma_start.
    put_desc(64'h40, mk_w0(16'h0010, 2'b10, 0, 1, 0), 64'h100);
    start_engine(64'h40, 1'b0);
    repeat (5) @(negedge clk);
    chk("inv_busy_c6", busy, 1);
    @(negedge clk);
    chk("inv_busy_c7", busy, 0);

    // Three-descriptor chain: tran, nop, tran+End+Int.
    put_desc(64'h40, mk_w0(16'h0008, 2'b10, 0, 0, 1), 64'h1000);
    put_desc(64'h44, mk_w0(16'h0000, 2'b00, 0, 0, 1), 64'h0);
    put_desc(64'h48, mk_w0(16'h0020, 2'b10, 1, 1, 1), 64'h2000);
    snap(); tfc_delay = 3;
    start_engine(64'h40, 1'b1);
    wait_idle(200);
    chk("chain_launches", launch_addr.size() - l0, 2);
    chk("chain_fetch1", fetch_log[f0 + 4], 64'h44);
    chk("chain_fetch2", fetch_log[f0 + 8], 64'h48);
    chk("chain_int", n_int - i0, 1);
    chk("chain_done", n_done - d0, 1);

    // Link to 0x200, then tran+End there.
    put_desc(64'h40, mk_w0(16'h0000, 2'b11, 0, 0, 1), 64'h200);
    put_desc(64'h200, mk_w0(16'h0004, 2'b10, 0, 1, 1), 64'h5000);
    snap();
    start_engine(64'h40, 1'b0);
    wait_idle(200);
    chk("link_fetch", fetch_log[f0 + 4], 64'h200);
    chk("link_launches", launch_addr.size() - l0, 1);
    chk("link_done", n_done - d0, 1);

    // desc_ptr wraps modulo 2^64.
    put_desc(64'hFFFF_FFFF_FFFF_FFFC, mk_w0(16'h0000, 2'b00, 0, 0, 1), 64'h0);
    put_desc(64'h0, mk_w0(16'h0002, 2'b10, 0, 1, 1), 64'h9000);
    snap();
    start_engine(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    wait_idle(200);
    chk("wrap_fetch", fetch_log[f0 + 4], 64'h0);
    chk("wrap_done", n_done - d0, 1);
    chk("wrap_error", error, 0);

    // adma_stop during fetch.
    put_desc(64'h40, mk_w0(16'h0010, 2'b10, 0, 1, 1), 64'h100);
    snap();
    start_engine(64'h40, 1'b0);
    adma_stop = 1'b1;
    @(negedge clk);
    adma_stop = 1'b0;
    chk("sfds_busy", busy, 0); chk("sfds_read", ram_read, 0); chk("sfds_fetch", fetch_active, 0);
    repeat (8) @(negedge clk);
    chk("sfds_nreads", fetch_log.size() - f0, 1);
    chk("sfds_launch", launch_addr.size() - l0, 0);
    chk("sfds_done", n_done - d0, 0);

    // adma_stop during transfer: holds until TFC, then no refetch.
    put_desc(64'h40, mk_w0(16'h0003, 2'b10, 0, 0, 1), 64'h700);
    put_desc(64'h44, mk_w0(16'h0003, 2'b10, 0, 1, 1), 64'h800);
    snap();
    start_engine(64'h40, 1'b0);
    for (int c = 0; c < 20 && !start_transfer; c++) @(negedge clk);
    chk("stfr_launched", start_transfer, 1);
    @(negedge clk);
    adma_stop = 1'b1; @(negedge clk); adma_stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("stfr_hold_busy", busy, 1); chk("stfr_hold_addr", address, 64'h700);
    chk("stfr_hold_len", length, 16'h3);
    TFC = 1'b1; @(negedge clk); TFC = 1'b0;
    chk("stfr_busy", busy, 0);
    repeat (8) @(negedge clk);
    chk("stfr_nreads", fetch_log.size() - f0, 4);
    chk("stfr_done", n_done - d0, 0);

    // Reset in ST_TFR, stale TFC, then a fresh run.
    put_desc(64'h40, mk_w0(16'h0005, 2'b10, 1, 1, 1), 64'h77);
    snap();
    start_engine(64'h40, 1'b1);
    for (int c = 0; c < 20 && !start_transfer; c++) @(negedge clk);
    @(negedge clk);
    RESET_L = 1'b0; @(negedge clk);
    chk_reset_state("rst_tfr");
    RESET_L = 1'b1;
    TFC = 1'b1; @(negedge clk); TFC = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stale_busy", busy, 0); chk("rst_stale_done", n_done - d0, 0);
    chk("rst_stale_int", n_int - i0, 0);
    snap(); tfc_delay = 2;
    start_engine(64'h40, 1'b1);
    wait_idle(100);
    chk("rst_rerun_launch", launch_addr.size() - l0, 1);
    chk("rst_rerun_done", n_done - d0, 1);
    chk("rst_rerun_int", n_int - i0, 1);

    // Randomized chains against the model.
    for (int it = 0; it < 30; it++) begin
      logic rdir;
      gen_chain(rbase);
      model_walk(rbase);
      snap(); rdir = 1'($urandom); tfc_delay = int'($urandom_range(1, 5));
      start_engine(rbase, rdir);
      wait_idle(1000);
      nl = launch_addr.size() - l0;
      chk("rnd_launches", nl, exp_addr.size());
      for (int j = 0; j < nl && j < exp_addr.size(); j++) begin
        chk("rnd_addr", launch_addr[l0 + j], exp_addr[j]);
        chk("rnd_len", launch_len[l0 + j], exp_len[j]);
        chk("rnd_dir", launch_dir[l0 + j], rdir);
      end
      chk("rnd_nreads", fetch_log.size() - f0, exp_fetch.size());
      for (int j = 0; j < exp_fetch.size() && f0 + j < fetch_log.size(); j++)
        chk("rnd_read_addr", fetch_log[f0 + j], exp_fetch[j]);
      chk("rnd_done", n_done - d0, exp_done);
      chk("rnd_int", n_int - i0, exp_int);
      chk("rnd_error", error, exp_err);
      chk("rnd_err_state", err_state, exp_err ? 2'b01 : 2'b00);
      chk("rnd_desc_ptr", desc_ptr, exp_ptr);
    end

    chk("read_outside_fds", n_bad_read, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
